// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: RAM command opcodes, FSM state encoding
// and default widths.
package ram_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_RD_TIMEOUT = 15;

   localparam logic [1:0] WR_ADDR = 2'b00;
   localparam logic [1:0] WR_DATA = 2'b01;
   localparam logic [1:0] RD_ADDR = 2'b10;
   localparam logic [1:0] RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CMD_ADDR,
      CMD_DATA,
      WAIT_RD,
      RESP
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant for ram_port_arbiter. Round-robin by default; defining ARB_FIXED_PRIO_EN
// makes requester 0 always win and removes the pointer.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic update,
   input  logic owner,
   output logic gnt0,
   output logic gnt1
);

`ifdef ARB_FIXED_PRIO_EN
   assign gnt0 = req0;
   assign gnt1 = req1 && !req0;
`else
   logic ptr;

   // After each completed transaction the other requester gets priority on a tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (update) begin
         ptr <= !owner;
      end
   end

   assign gnt0 = req0 && (!req1 || !ptr);
   assign gnt1 = req1 && (!req0 || ptr);
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port RAM between two requesters, sequencing whole transactions into
// the two-phase {opcode, payload} command protocol. ARB_FIXED_PRIO_EN selects fixed priority.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_wr,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_wr,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp0_err,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  rsp1_err,
   output logic [ADDR_WIDTH+1:0] ram_din,
   output logic                  ram_rx_valid,
   input  logic                  ram_tx_valid,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   state_t                state;
   logic                  cur_wr;
   logic                  cur_owner;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic [CNT_W-1:0]      rd_cnt;
   logic                  gnt0;
   logic                  gnt1;
   logic                  accept;
   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [ADDR_WIDTH-1:0] data_payload;
   logic                  fin;
   logic [DATA_WIDTH-1:0] fin_rdata;
   logic                  fin_err;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0_valid),
      .req1   (req1_valid),
      .update (state == RESP),
      .owner  (cur_owner),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   assign req0_ready   = !rst && (state == IDLE) && gnt0;
   assign req1_ready   = !rst && (state == IDLE) && gnt1;
   assign accept       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign sel_wr       = gnt1 ? req1_wr    : req0_wr;
   assign sel_addr     = gnt1 ? req1_addr  : req0_addr;
   assign sel_wdata    = gnt1 ? req1_wdata : req0_wdata;
   assign data_payload = cur_wr ? ADDR_WIDTH'(cur_wdata) : '0;

   // Completion of the current transaction; tx_valid takes precedence over the timeout
   always_comb begin
      fin       = 1'b0;
      fin_rdata = '0;
      fin_err   = 1'b0;
      if (state == CMD_DATA && cur_wr) begin
         fin = 1'b1;
      end else if (state == WAIT_RD) begin
         if (ram_tx_valid) begin
            fin       = 1'b1;
            fin_rdata = ram_dout;
         end else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            fin     = 1'b1;
            fin_err = 1'b1;
         end
      end
   end

   // Transaction sequencer; the RAM strobe and response pulses default low every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cur_wr       <= 1'b0;
         cur_owner    <= 1'b0;
         cur_addr     <= '0;
         cur_wdata    <= '0;
         rd_cnt       <= '0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         rsp0_valid   <= 1'b0;
         rsp0_rdata   <= '0;
         rsp0_err     <= 1'b0;
         rsp1_valid   <= 1'b0;
         rsp1_rdata   <= '0;
         rsp1_err     <= 1'b0;
      end else begin
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         rsp0_valid   <= fin && !cur_owner;
         rsp0_rdata   <= (fin && !cur_owner) ? fin_rdata : '0;
         rsp0_err     <= fin && !cur_owner && fin_err;
         rsp1_valid   <= fin && cur_owner;
         rsp1_rdata   <= (fin && cur_owner) ? fin_rdata : '0;
         rsp1_err     <= fin && cur_owner && fin_err;
         case (state)
            IDLE: begin
               if (accept) begin
                  cur_wr       <= sel_wr;
                  cur_owner    <= gnt1;
                  cur_addr     <= sel_addr;
                  cur_wdata    <= sel_wdata;
                  ram_din      <= {sel_wr ? WR_ADDR : RD_ADDR, sel_addr};
                  ram_rx_valid <= 1'b1;
                  state        <= CMD_ADDR;
               end
            end
            CMD_ADDR: begin
               ram_din      <= {cur_wr ? WR_DATA : RD_DATA, data_payload};
               ram_rx_valid <= 1'b1;
               state        <= CMD_DATA;
            end
            CMD_DATA: begin
               rd_cnt <= '0;
               state  <= cur_wr ? RESP : WAIT_RD;
            end
            WAIT_RD: begin
               rd_cnt <= rd_cnt + CNT_W'(1);
               if (fin) begin
                  state <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: acts as the RAM and checks every transaction
// against a transaction-level model of arbitration, command words, latency and responses.
module tb_ram_port_arbiter;

   localparam int TO = 15;
`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic       req0_wr = 1'b0, req1_wr = 1'b0;
   logic [7:0] req0_addr = '0, req1_addr = '0;
   logic [7:0] req0_wdata = '0, req1_wdata = '0;
   logic       rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
   logic [7:0] rsp0_rdata, rsp1_rdata;
   logic [9:0] ram_din;
   logic       ram_rx_valid;
   logic       ram_tx_valid = 1'b0;
   logic [7:0] ram_dout = '0;
   logic [32:0] all_outs;

   int         checks = 0;
   int         errors = 0;
   int         ptr_m  = 0;
   logic [7:0] mem_m [256];

   always #5 clk = ~clk;

   assign all_outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                      ram_rx_valid, rsp0_rdata, rsp1_rdata, ram_din};

   ram_port_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_wr      (req0_wr),
      .req0_addr    (req0_addr),
      .req0_wdata   (req0_wdata),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_wr      (req1_wr),
      .req1_addr    (req1_addr),
      .req1_wdata   (req1_wdata),
      .rsp0_valid   (rsp0_valid),
      .rsp0_rdata   (rsp0_rdata),
      .rsp0_err     (rsp0_err),
      .rsp1_valid   (rsp1_valid),
      .rsp1_rdata   (rsp1_rdata),
      .rsp1_err     (rsp1_err),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_tx_valid (ram_tx_valid),
      .ram_dout     (ram_dout)
   );

   // Transaction-level model: who wins, what two commands appear, when and what the response is
   function automatic void model(input logic v0, input logic v1, input logic w0, input logic w1,
                                 input logic [7:0] a0, input logic [7:0] a1,
                                 input logic [7:0] d0, input logic [7:0] d1, input int txd,
                                 output int g, output logic [21:0] cmds, output int lat,
                                 output logic [7:0] rd, output logic er);
      logic       w;
      logic [7:0] a, d;
      if (v0 && v1) g = FIXED ? 0 : ptr_m;
      else          g = v0 ? 0 : 1;
      w = (g == 1) ? w1 : w0;
      a = (g == 1) ? a1 : a0;
      d = (g == 1) ? d1 : d0;
      cmds = {(w ? 2'b00 : 2'b10), a, 1'b1, (w ? 2'b01 : 2'b11), (w ? d : 8'h00), 1'b1};
      if (w) begin
         lat = 3; rd = 8'h00; er = 1'b0;
      end else if (txd >= 0 && txd < TO) begin
         lat = 4 + txd; rd = mem_m[a]; er = 1'b0;
      end else begin
         lat = 3 + TO; rd = 8'h00; er = 1'b1;
      end
      ptr_m = 1 - g;
      if (w) mem_m[a] = d;
   endfunction

   // Drives one request set, plays the RAM, and reports what the DUT did (cycle counts from accept edge)
   task automatic txn(input logic v0, input logic v1, input logic w0, input logic w1,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1, input int txd, input bit keep,
                      output int g, output logic [21:0] cmds, output int lat,
                      output logic [7:0] rd, output logic er, output logic bad);
      req0_valid = v0; req1_valid = v1; req0_wr = w0; req1_wr = w1;
      req0_addr = a0; req1_addr = a1; req0_wdata = d0; req1_wdata = d1;
      g = -1; cmds = '0; lat = -1; rd = '0; er = 1'b0; bad = 1'b0;
      #1;
      if (req0_ready && !req1_ready) g = 0;
      else if (req1_ready && !req0_ready) g = 1;
      @(posedge clk); #1;
      if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (g >= 0) begin
         cmds[21:11] = {ram_din, ram_rx_valid};
         if (req0_ready || req1_ready) bad = 1'b1;
         @(posedge clk); #1;
         cmds[10:0] = {ram_din, ram_rx_valid};
         if (req0_ready || req1_ready) bad = 1'b1;
         for (int k = 3; k <= TO + 8 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (ram_rx_valid || req0_ready || req1_ready) bad = 1'b1;
            if (rsp0_valid || rsp1_valid) begin
               lat = k;
               rd  = rsp0_valid ? rsp0_rdata : rsp1_rdata;
               er  = rsp0_valid ? rsp0_err : rsp1_err;
               if (rsp0_valid && rsp1_valid) bad = 1'b1;
               if ((g == 0) ? !rsp0_valid : !rsp1_valid) bad = 1'b1;
            end else if (txd >= 0 && k - 3 == txd) begin
               ram_tx_valid = 1'b1;
               ram_dout     = mem_m[cmds[19:12]];
            end else begin
               ram_tx_valid = 1'b0;
               ram_dout     = 8'($urandom);
            end
         end
         ram_tx_valid = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if (all_outs !== 33'd0) begin
         errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", all_outs);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write;
      int g, eg, lat, elat; logic [21:0] cmds, ecmds; logic [7:0] rd, erd; logic er, eer, bad;
      model(1, 0, 1, 0, 8'h3C, 8'h00, 8'hA5, 8'h00, -1, eg, ecmds, elat, erd, eer);
      txn(1, 0, 1, 0, 8'h3C, 8'h00, 8'hA5, 8'h00, -1, 0, g, cmds, lat, rd, er, bad);
      checks++;
      if (g !== eg) begin errors++; $display("[TB] FAIL write grant: got %0d expected %0d", g, eg); end
      checks++;
      if (cmds !== ecmds) begin errors++; $display("[TB] FAIL write cmds: got %h expected %h", cmds, ecmds); end
      checks++;
      if (lat !== elat || rd !== erd || er !== eer || bad !== 1'b0) begin
         errors++;
         $display("[TB] FAIL write rsp: got lat=%0d rdata=%h err=%b bad=%b expected lat=%0d rdata=%h err=%b bad=0",
                  lat, rd, er, bad, elat, erd, eer);
      end
   endtask

   task automatic test_read;
      int g, eg, lat, elat; logic [21:0] cmds, ecmds; logic [7:0] rd, erd; logic er, eer, bad;
      model(0, 1, 0, 0, 8'h00, 8'h3C, 8'h00, 8'h77, 2, eg, ecmds, elat, erd, eer);
      txn(0, 1, 0, 0, 8'h00, 8'h3C, 8'h00, 8'h77, 2, 0, g, cmds, lat, rd, er, bad);
      checks++;
      if (g !== eg) begin errors++; $display("[TB] FAIL read grant: got %0d expected %0d", g, eg); end
      checks++;
      if (cmds !== ecmds) begin errors++; $display("[TB] FAIL read cmds: got %h expected %h", cmds, ecmds); end
      checks++;
      if (lat !== elat || rd !== erd || er !== eer || bad !== 1'b0) begin
         errors++;
         $display("[TB] FAIL read rsp: got lat=%0d rdata=%h err=%b bad=%b expected lat=%0d rdata=%h err=%b bad=0",
                  lat, rd, er, bad, elat, erd, eer);
      end
   endtask

   task automatic test_back_to_back;
      int g, eg, lat, elat; logic [21:0] cmds, ecmds; logic [7:0] rd, erd; logic er, eer, bad;
      for (int i = 0; i < 4; i++) begin
         model(1, 1, 1, 1, 8'h10, 8'h20, 8'h11, 8'h22, -1, eg, ecmds, elat, erd, eer);
         txn(1, 1, 1, 1, 8'h10, 8'h20, 8'h11, 8'h22, -1, 1, g, cmds, lat, rd, er, bad);
         checks++;
         if (g !== eg) begin errors++; $display("[TB] FAIL b2b%0d grant: got %0d expected %0d", i, g, eg); end
         checks++;
         if (cmds !== ecmds) begin errors++; $display("[TB] FAIL b2b%0d cmds: got %h expected %h", i, cmds, ecmds); end
         checks++;
         if (lat !== elat || rd !== erd || er !== eer || bad !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b%0d rsp: got lat=%0d rdata=%h err=%b bad=%b expected lat=%0d rdata=%h err=%b bad=0",
                     i, lat, rd, er, bad, elat, erd, eer);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_timeout;
      int g, eg, lat, elat; logic [21:0] cmds, ecmds; logic [7:0] rd, erd; logic er, eer, bad;
      int txd_tab [4] = '{-1, TO - 1, TO, -1};
      for (int i = 0; i < 4; i++) begin
         logic w = (i == 3);
         model(1, 0, w, 0, 8'h3C, 8'h00, 8'h5A, 8'h00, txd_tab[i], eg, ecmds, elat, erd, eer);
         txn(1, 0, w, 0, 8'h3C, 8'h00, 8'h5A, 8'h00, txd_tab[i], 0, g, cmds, lat, rd, er, bad);
         checks++;
         if (g !== eg) begin errors++; $display("[TB] FAIL tmo%0d grant: got %0d expected %0d", i, g, eg); end
         checks++;
         if (cmds !== ecmds) begin errors++; $display("[TB] FAIL tmo%0d cmds: got %h expected %h", i, cmds, ecmds); end
         checks++;
         if (lat !== elat || rd !== erd || er !== eer || bad !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tmo%0d rsp: got lat=%0d rdata=%h err=%b bad=%b expected lat=%0d rdata=%h err=%b bad=0",
                     i, lat, rd, er, bad, elat, erd, eer);
         end
      end
   endtask

   task automatic test_reset_in_wait;
      int g, eg, lat, elat; logic [21:0] cmds, ecmds; logic [7:0] rd, erd; logic er, eer, bad;
      logic seen = 1'b0;
      req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 8'h55;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      req0_valid = 1'b1; req1_valid = 1'b1;
      rst = 1'b1;
      #1;
      checks++;
      if (all_outs !== 33'd0) begin
         errors++; $display("[TB] FAIL rst_wait outputs: got %h expected 0", all_outs);
      end
      @(negedge clk);
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      ptr_m = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rsp0_valid || rsp1_valid || ram_rx_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait no_rsp: got activity=%b expected 0", seen); end
      model(1, 1, 0, 1, 8'h3C, 8'h40, 8'h00, 8'h44, 0, eg, ecmds, elat, erd, eer);
      txn(1, 1, 0, 1, 8'h3C, 8'h40, 8'h00, 8'h44, 0, 0, g, cmds, lat, rd, er, bad);
      checks++;
      if (g !== eg) begin errors++; $display("[TB] FAIL rst_wait grant: got %0d expected %0d", g, eg); end
      checks++;
      if (cmds !== ecmds) begin errors++; $display("[TB] FAIL rst_wait cmds: got %h expected %h", cmds, ecmds); end
      checks++;
      if (lat !== elat || rd !== erd || er !== eer || bad !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_wait rsp: got lat=%0d rdata=%h err=%b bad=%b expected lat=%0d rdata=%h err=%b bad=0",
                  lat, rd, er, bad, elat, erd, eer);
      end
   endtask

   task automatic test_addr_ff;
      int g, eg, lat, elat; logic [21:0] cmds, ecmds; logic [7:0] rd, erd; logic er, eer, bad;
      for (int i = 0; i < 2; i++) begin
         logic w = (i == 0);
         model(w, !w, w, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1, eg, ecmds, elat, erd, eer);
         txn(w, !w, w, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1, 0, g, cmds, lat, rd, er, bad);
         checks++;
         if (g !== eg) begin errors++; $display("[TB] FAIL ff%0d grant: got %0d expected %0d", i, g, eg); end
         checks++;
         if (cmds !== ecmds) begin errors++; $display("[TB] FAIL ff%0d cmds: got %h expected %h", i, cmds, ecmds); end
         checks++;
         if (lat !== elat || rd !== erd || er !== eer || bad !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ff%0d rsp: got lat=%0d rdata=%h err=%b bad=%b expected lat=%0d rdata=%h err=%b bad=0",
                     i, lat, rd, er, bad, elat, erd, eer);
         end
      end
   endtask

   task automatic test_random;
      int g, eg, lat, elat; logic [21:0] cmds, ecmds; logic [7:0] rd, erd; logic er, eer, bad;
      for (int i = 0; i < 24; i++) begin
         logic v0 = 1'($urandom_range(0, 1));
         logic v1 = 1'($urandom_range(0, 1));
         logic w0 = 1'($urandom_range(0, 1));
         logic w1 = 1'($urandom_range(0, 1));
         logic [7:0] a0 = 8'($urandom_range(248, 255));
         logic [7:0] a1 = 8'($urandom_range(248, 255));
         logic [7:0] d0 = 8'($urandom);
         logic [7:0] d1 = 8'($urandom);
         int r = int'($urandom_range(0, TO + 3));
         int txd = (r > TO + 1) ? -1 : r;
         if (!v0 && !v1) v0 = 1'b1;
         model(v0, v1, w0, w1, a0, a1, d0, d1, txd, eg, ecmds, elat, erd, eer);
         txn(v0, v1, w0, w1, a0, a1, d0, d1, txd, 0, g, cmds, lat, rd, er, bad);
         checks++;
         if (g !== eg) begin errors++; $display("[TB] FAIL rnd%0d grant: got %0d expected %0d", i, g, eg); end
         checks++;
         if (cmds !== ecmds) begin errors++; $display("[TB] FAIL rnd%0d cmds: got %h expected %h", i, cmds, ecmds); end
         checks++;
         if (lat !== elat || rd !== erd || er !== eer || bad !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rnd%0d rsp: got lat=%0d rdata=%h err=%b bad=%b expected lat=%0d rdata=%h err=%b bad=0",
                     i, lat, rd, er, bad, elat, erd, eer);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_timeout();
      test_reset_in_wait();
      test_addr_ff();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
